stack_seq: RTL and testbench
============================

Name: stack_seq

Overview:
Multi-cycle stack-operation sequencer that sits directly upstream of the 16-bit stack pointer register. It drives the pointer's read/push/pop strobes and the data-memory bus to execute PUSH, POP, CALL and RET. It accepts one operation at a time from the control unit and returns popped data or a new PC. It checks stack overflow/underflow before touching the pointer and enforces a memory wait-state timeout.

Parameters:
STACK_LIMIT, 16'hFF00, lowest legal stack address; stack occupies [STACK_LIMIT, 16'hFFFF]; empty SP = 16'h0000
TIMEOUT, 16, max MEM cycles without mem_ack before bus error; 0 = wait forever; range 0..255

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
op_valid  in  1  operation request
op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
op_data  in  16  PUSH value / CALL target
pc_in  in  16  return address for CALL
op_ready  out  1  high only in IDLE
done  out  1  1-cycle pulse at completion (success, fault or bus error)
fault  out  1  1-cycle pulse: overflow (PUSH/CALL) or underflow (POP/RET)
bus_err  out  1  1-cycle pulse: mem_ack timeout
result  out  16  last POP data, held until next POP
pc_out  out  16  new PC for CALL/RET, held
pc_load  out  1  1-cycle pulse, coincident with done on CALL/RET success
sp_val  in  16  current SP value (SP data-bus output)
sp_read  out  1  SP read-to-data-bus enable
sp_push  out  1  SP push strobe
sp_pop  out  1  SP pop strobe
mem_addr  out  16  memory address
mem_wdata  out  16  write data
mem_rdata  in  16  read data, valid with mem_ack
mem_we  out  1  write request
mem_re  out  1  read request
mem_ack  in  1  memory completion, sampled on posedge

Behaviour:
- Reset (sync, any state): state=IDLE; all strobes, done/fault/bus_err/pc_load = 0; result=pc_out=mem_addr=mem_wdata=0; wait counter=0. Reset mid-operation abandons the op with no done pulse. The SP is reset separately.
- IDLE: op_ready=1. If op_valid is high at a posedge, latch op, op_data and pc_in, then go to CHECK. Requests while not IDLE are ignored.
- CHECK (1 cycle): sp_read=1; sample sp_val.
  - PUSH/CALL: overflow if sp_val==STACK_LIMIT. Otherwise addr_r <= sp_val-1 (16-bit wrap, so 0x0000 -> 0xFFFF). wdata_r <= op_data for PUSH, pc_in for CALL.
  - POP/RET: underflow if sp_val==16'h0000. Otherwise addr_r <= sp_val.
  - Fault -> FAULT; else -> ADJ.
- FAULT (1 cycle): fault=1, done=1 -> IDLE. No SP strobe and no memory access.
- ADJ (1 cycle): sp_push=1 (PUSH/CALL) or sp_pop=1 (POP/RET), exactly one cycle -> MEM.
- MEM: mem_addr=addr_r; mem_we=1 (PUSH/CALL) or mem_re=1 (POP/RET); address/data held stable until mem_ack.
  - Counter increments each MEM cycle without ack.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: -> BERR. The SP is not restored.
  - On mem_ack: POP -> result<=mem_rdata; RET -> pc_out<=mem_rdata; CALL -> pc_out<=latched op_data. Clear counter -> DONE.
  - mem_ack outside MEM is ignored.
- BERR (1 cycle): bus_err=1, done=1; counter cleared -> IDLE.
- DONE (1 cycle): done=1; pc_load=1 for CALL/RET -> IDLE.
- Latency with zero-wait memory (ack in first MEM cycle), accept at edge 0: CHECK cycle 1, ADJ 2, MEM 3, done in cycle 4. Back-to-back ops: the next accept is at the cycle-5 edge. Each extra wait cycle adds 1.
- At most one of sp_read/sp_push/sp_pop is high in any cycle; all three are low in IDLE.

Decomposition:
- Shared include srp16_stack_defs.vh: op codes (OP_PUSH..OP_RET), state encodings (IDLE, CHECK, ADJ, MEM, FAULT, BERR, DONE), reset value 16'h0000.
- One sub-module, bus_timer: 8-bit wait counter with clear/enable inputs and an expired output compared against TIMEOUT.

Test Plan:
- Reset then PUSH op_data=16'h1234, sp_val=0x0000, ack in first MEM cycle -> sp_push 1 cycle; mem_we with mem_addr=0xFFFF, wdata=0x1234; done in cycle 4; no fault.
- POP with sp_val=0xFFFE, mem_rdata=0xBEEF, ack after 3 wait cycles -> sp_pop 1 cycle; mem_re at 0xFFFE held 4 cycles; result=0xBEEF; done in cycle 7.
- CALL op_data=0x0400, pc_in=0x0123, sp_val=0xFFF0 -> write 0x0123 at 0xFFEF; pc_out=0x0400; pc_load coincident with done. RET with sp_val=0xFFEF, rdata=0x0123 -> pc_out=0x0123, pc_load pulse.
- PUSH with sp_val=0xFF00 -> fault+done in cycle 2; no sp_push, mem_we or mem_re. POP with sp_val=0x0000 -> same underflow response.
- PUSH with mem_ack never asserted, TIMEOUT=16 -> bus_err+done after 16 MEM cycles; op_ready=1 on the following cycle.
- reset asserted in MEM -> next cycle IDLE; mem_we=0; no done; a later late mem_ack is ignored.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack-operation sequencer: operation codes,
// FSM state encodings, the SP reset value and a small op classifier.
package stack_seq_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADJ   = 3'd2,
    ST_MEM   = 3'd3,
    ST_FAULT = 3'd4,
    ST_BERR  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [15:0] SP_RESET = 16'h0000;

  // PUSH and CALL grow the stack (write); POP and RET shrink it (read).
  function automatic logic is_write(input op_t o);
    return (o == OP_PUSH) || (o == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_seq_bus_timer.sv
// Memory wait-state counter. 'expired' is asserted combinationally during the
// TIMEOUT-th consecutive enabled cycle, so the owner can leave on that edge.
// TIMEOUT = 0 disables expiry (wait forever).
module bus_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [8:0] TIMEOUT_9 = 9'(TIMEOUT);

  logic [7:0] count;

  // Count enabled cycles; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Expiry fires on the cycle that would make the count reach TIMEOUT.
  always_comb begin
    expired = 1'b0;
    if (TIMEOUT != 0 && enable && (({1'b0, count} + 9'd1) == TIMEOUT_9)) begin
      expired = 1'b1;
    end
  end

endmodule

// File: rtl/stack_seq.sv
// Stack-operation sequencer in front of the 16-bit stack pointer register.
// Executes PUSH/POP/CALL/RET as CHECK -> ADJ -> MEM -> DONE, with an
// overflow/underflow check before the SP is touched and a bus timeout in MEM.
// Handshake: an op is accepted on a posedge where op_valid && op_ready;
// op_ready is high only in IDLE, and requests at other times are ignored.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter logic [15:0] STACK_LIMIT = 16'hFF00,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [15:0] op_data,
  input  logic [15:0] pc_in,
  output logic        op_ready,
  output logic        done,
  output logic        fault,
  output logic        bus_err,
  output logic [15:0] result,
  output logic [15:0] pc_out,
  output logic        pc_load,
  input  logic [15:0] sp_val,
  output logic        sp_read,
  output logic        sp_push,
  output logic        sp_pop,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic        mem_ack,
  output logic [2:0]  dbg_state
);

  state_t      state, state_nx;
  op_t         op_r;
  logic [15:0] data_r;
  logic [15:0] pc_r;
  logic [15:0] addr_r;
  logic [15:0] wdata_r;
  logic        chk_fail;
  logic        tmr_clear;
  logic        tmr_en;
  logic        tmr_expired;

  assign dbg_state = state;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  // Stack bound check on the SP value sampled in CHECK.
  assign chk_fail = is_write(op_r) ? (sp_val == STACK_LIMIT) : (sp_val == SP_RESET);

  // Timer runs only while waiting in MEM; any other state or an ack clears it.
  assign tmr_en    = (state == ST_MEM) && !mem_ack;
  assign tmr_clear = (state != ST_MEM) || mem_ack;

  bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and Moore-style strobes.
  always_comb begin
    state_nx = state;
    op_ready = 1'b0;
    done     = 1'b0;
    fault    = 1'b0;
    bus_err  = 1'b0;
    pc_load  = 1'b0;
    sp_read  = 1'b0;
    sp_push  = 1'b0;
    sp_pop   = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        sp_read  = 1'b1;
        state_nx = chk_fail ? ST_FAULT : ST_ADJ;
      end
      ST_FAULT: begin
        fault    = 1'b1;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_ADJ: begin
        sp_push  = is_write(op_r);
        sp_pop   = !is_write(op_r);
        state_nx = ST_MEM;
      end
      ST_MEM: begin
        mem_we = is_write(op_r);
        mem_re = !is_write(op_r);
        if (mem_ack)          state_nx = ST_DONE;
        else if (tmr_expired) state_nx = ST_BERR;
      end
      ST_BERR: begin
        bus_err  = 1'b1;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_DONE: begin
        done     = 1'b1;
        pc_load  = (op_r == OP_CALL) || (op_r == OP_RET);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operation latch, address/data setup in CHECK and result capture on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r    <= OP_PUSH;
      data_r  <= 16'h0000;
      pc_r    <= 16'h0000;
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      result  <= 16'h0000;
      pc_out  <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_r   <= op_t'(op);
            data_r <= op_data;
            pc_r   <= pc_in;
          end
        end
        ST_CHECK: begin
          if (!chk_fail) begin
            if (is_write(op_r)) begin
              addr_r  <= sp_val - 16'd1;
              wdata_r <= (op_r == OP_CALL) ? pc_r : data_r;
            end else begin
              addr_r <= sp_val;
            end
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            case (op_r)
              OP_POP:  result <= mem_rdata;
              OP_RET:  pc_out <= mem_rdata;
              OP_CALL: pc_out <= data_r;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: each step drives inputs just after a posedge
// and checks outputs in the same cycle, with cycle numbers counted from the
// accepting edge (edge 0).
module tb_stack_seq;
  import stack_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op;
  logic [15:0] op_data;
  logic [15:0] pc_in;
  logic        op_ready;
  logic        done;
  logic        fault;
  logic        bus_err;
  logic [15:0] result;
  logic [15:0] pc_out;
  logic        pc_load;
  logic [15:0] sp_val;
  logic        sp_read;
  logic        sp_push;
  logic        sp_pop;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic        mem_re;
  logic        mem_ack;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  stack_seq dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (op),
    .op_data   (op_data),
    .pc_in     (pc_in),
    .op_ready  (op_ready),
    .done      (done),
    .fault     (fault),
    .bus_err   (bus_err),
    .result    (result),
    .pc_out    (pc_out),
    .pc_load   (pc_load),
    .sp_val    (sp_val),
    .sp_read   (sp_read),
    .sp_push   (sp_push),
    .sp_pop    (sp_pop),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Present an op in IDLE and let the next edge (edge 0) accept it.
  task automatic issue(input logic [1:0] o, input logic [15:0] d, input logic [15:0] pc);
    op_valid = 1'b1;
    op       = o;
    op_data  = d;
    pc_in    = pc;
    tick();
    op_valid = 1'b0;
  endtask

  // One-hot summary of the SP strobes {read, push, pop} and memory {we, re}.
  function automatic logic [15:0] strobes();
    return {11'd0, sp_read, sp_push, sp_pop, mem_we, mem_re};
  endfunction

  initial begin
    reset     = 1'b1;
    op_valid  = 1'b0;
    op        = 2'b00;
    op_data   = 16'h0000;
    pc_in     = 16'h0000;
    sp_val    = 16'h0000;
    mem_rdata = 16'h0000;
    mem_ack   = 1'b0;
    tick();
    tick();

    // Reset state.
    chk("rst_ready",   16'(op_ready), 16'd1);
    chk("rst_state",   16'(dbg_state), 16'(ST_IDLE));
    chk("rst_strobes", strobes(), 16'h0000);
    chk("rst_done",    {13'd0, done, fault, bus_err}, 16'h0000);
    chk("rst_result",  result, 16'h0000);
    chk("rst_pc_out",  pc_out, 16'h0000);
    chk("rst_addr",    mem_addr, 16'h0000);
    chk("rst_wdata",   mem_wdata, 16'h0000);
    reset = 1'b0;
    tick();

    // PUSH 0x1234 at empty SP, zero-wait memory.
    sp_val = 16'h0000;
    issue(2'b00, 16'h1234, 16'h0000);
    chk("push_c1_strobes", strobes(), 16'b10000);          // sp_read
    chk("push_c1_ready",   16'(op_ready), 16'd0);
    tick();
    chk("push_c2_strobes", strobes(), 16'b01000);          // sp_push
    tick();
    chk("push_c3_strobes", strobes(), 16'b00010);          // mem_we
    chk("push_c3_addr",    mem_addr, 16'hFFFF);
    chk("push_c3_wdata",   mem_wdata, 16'h1234);
    chk("push_c3_done",    16'(done), 16'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("push_c4_done",    {13'd0, done, fault, bus_err}, 16'b100);
    chk("push_c4_pcload",  16'(pc_load), 16'd0);
    chk("push_c4_strobes", strobes(), 16'h0000);
    tick();
    chk("push_c5_ready",   16'(op_ready), 16'd1);
    chk("push_c5_done",    16'(done), 16'd0);

    // POP at SP=0xFFFE with three wait cycles; a stray request during the op is ignored.
    sp_val    = 16'hFFFE;
    mem_rdata = 16'hBEEF;
    issue(2'b01, 16'h0000, 16'h0000);
    chk("pop_c1_strobes", strobes(), 16'b10000);
    tick();
    chk("pop_c2_strobes", strobes(), 16'b00100);           // sp_pop
    op_valid = 1'b1;
    op       = 2'b00;
    tick();
    op_valid = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      chk($sformatf("pop_c%0d_strobes", c), strobes(), 16'b00001);
      chk($sformatf("pop_c%0d_addr", c), mem_addr, 16'hFFFE);
      chk($sformatf("pop_c%0d_done", c), 16'(done), 16'd0);
      if (c == 6) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("pop_c7_done",   {13'd0, done, fault, bus_err}, 16'b100);
    chk("pop_c7_result", result, 16'hBEEF);
    chk("pop_c7_pcload", 16'(pc_load), 16'd0);
    tick();
    chk("pop_c8_ready",  16'(op_ready), 16'd1);
    chk("pop_c8_state",  16'(dbg_state), 16'(ST_IDLE));

    // CALL 0x0400 from PC 0x0123 at SP=0xFFF0.
    sp_val = 16'hFFF0;
    issue(2'b10, 16'h0400, 16'h0123);
    tick();
    chk("call_c2_strobes", strobes(), 16'b01000);
    tick();
    chk("call_c3_strobes", strobes(), 16'b00010);
    chk("call_c3_addr",    mem_addr, 16'hFFEF);
    chk("call_c3_wdata",   mem_wdata, 16'h0123);
    chk("call_c3_pcload",  16'(pc_load), 16'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("call_c4_done",    16'(done), 16'd1);
    chk("call_c4_pcload",  16'(pc_load), 16'd1);
    chk("call_c4_pc_out",  pc_out, 16'h0400);
    chk("call_c4_result",  result, 16'hBEEF);
    tick();
    chk("call_c5_pcload",  16'(pc_load), 16'd0);

    // RET at SP=0xFFEF returning 0x0123.
    sp_val    = 16'hFFEF;
    mem_rdata = 16'h0123;
    issue(2'b11, 16'h0000, 16'h0000);
    tick();
    chk("ret_c2_strobes", strobes(), 16'b00100);
    tick();
    chk("ret_c3_strobes", strobes(), 16'b00001);
    chk("ret_c3_addr",    mem_addr, 16'hFFEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ret_c4_done",    16'(done), 16'd1);
    chk("ret_c4_pcload",  16'(pc_load), 16'd1);
    chk("ret_c4_pc_out",  pc_out, 16'h0123);
    tick();

    // PUSH at the stack limit: overflow.
    sp_val = 16'hFF00;
    issue(2'b00, 16'h5555, 16'h0000);
    chk("ovf_c1_strobes", strobes(), 16'b10000);
    tick();
    chk("ovf_c2_flags",   {13'd0, done, fault, bus_err}, 16'b110);
    chk("ovf_c2_strobes", strobes(), 16'h0000);
    tick();
    chk("ovf_c3_ready",   16'(op_ready), 16'd1);
    chk("ovf_c3_strobes", strobes(), 16'h0000);
    chk("ovf_c3_fault",   16'(fault), 16'd0);

    // POP at the empty SP: underflow, result untouched.
    sp_val = 16'h0000;
    issue(2'b01, 16'h0000, 16'h0000);
    tick();
    chk("udf_c2_flags",   {13'd0, done, fault, bus_err}, 16'b110);
    chk("udf_c2_strobes", strobes(), 16'h0000);
    tick();
    chk("udf_c3_strobes", strobes(), 16'h0000);
    chk("udf_c3_result",  result, 16'hBEEF);

    // PUSH with no ack: bus error after 16 MEM cycles.
    sp_val = 16'hFFF0;
    issue(2'b00, 16'hAAAA, 16'h0000);
    tick();
    tick();
    for (int c = 3; c <= 18; c++) begin
      chk($sformatf("to_c%0d_we", c), 16'(mem_we), 16'd1);
      chk($sformatf("to_c%0d_flags", c), {13'd0, done, fault, bus_err}, 16'b000);
      tick();
    end
    chk("to_c19_flags",  {13'd0, done, fault, bus_err}, 16'b101);
    chk("to_c19_we",     16'(mem_we), 16'd0);
    tick();
    chk("to_c20_ready",  16'(op_ready), 16'd1);
    chk("to_c20_flags",  {13'd0, done, fault, bus_err}, 16'b000);

    // Reset during MEM abandons the op; a late ack is ignored.
    sp_val = 16'hFFF0;
    issue(2'b00, 16'h7777, 16'h0000);
    tick();
    tick();
    chk("rmem_c3_we",    16'(mem_we), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmem_c4_state", 16'(dbg_state), 16'(ST_IDLE));
    chk("rmem_c4_we",    16'(mem_we), 16'd0);
    chk("rmem_c4_done",  16'(done), 16'd0);
    chk("rmem_c4_addr",  mem_addr, 16'h0000);
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    chk("rmem_c5_done",  {13'd0, done, fault, bus_err}, 16'b000);
    chk("rmem_c5_ready", 16'(op_ready), 16'd1);
    chk("rmem_c5_result", result, 16'h0000);
    tick();
    chk("rmem_c6_state", 16'(dbg_state), 16'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
